agc_timer_writer: RTL
=====================

Name: agc_timer_writer

Overview:
- Producer side of the register file's second write port for the TIME1/TIME2 timer registers.
- Divides the core clock into timer ticks and accumulates pending increments.
- Issues request/grant-handshaked writes of TIME1+1, and on TIME1 overflow also TIME2+1, into the register file.
- Snoops pipeline writes to TIME1/TIME2 so its shadow copies always match architectural state.

Parameters:
- TICK_DIV, 100000, core-clock cycles per timer tick (≥2).
- MAX_PEND, 7, saturation limit of the pending-tick counter.

Ports:
- clock  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- grant  in  1  register-file port 2 is free this cycle; a presented write commits at this posedge.
- snoop1_en  in  1  pipeline write port 1 enable.
- snoop1_sel  in  reg_t  pipeline write port 1 destination.
- snoop1_data  in  15  pipeline write port 1 data.
- snoop2_en  in  1  pipeline write port 2 enable.
- snoop2_sel  in  reg_t  pipeline write port 2 destination.
- snoop2_data  in  15  pipeline write port 2 data.
- wr_req  out  1  write request to the port-2 arbiter.
- wr_sel  out  reg_t  destination, TIME1 or TIME2.
- wr_data  out  15  value to write.
- pend_cnt  out  $clog2(MAX_PEND+1)  outstanding ticks, for debug and test.
- overrun  out  1  sticky: a tick arrived while pend_cnt==MAX_PEND.

Behaviour:
- Reset (async, rst=1): prescaler=0, pend_cnt=0, shadow_t1=0, shadow_t2=0, state=IDLE, wr_req=0, wr_sel=TIME1, wr_data=0, overrun=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. A tick pulses on the cycle the count wraps to 0. The first tick after reset occurs at cycle TICK_DIV.
- pend_cnt:
  - tick alone: +1 (saturating).
  - TIME1 write commit alone: -1.
  - both in the same cycle: unchanged.
  - tick while pend_cnt==MAX_PEND (and no commit): stays MAX_PEND, overrun<=1. overrun clears only on reset.
- Arithmetic: TIME1/TIME2 use bits 13:0 only, as an unsigned modulo-2^14 counter; bit 14 is written as 0. TIME1 overflow = shadow_t1[13:0]==14'h3FFF.
- FSM (Moore outputs, registered):
  - IDLE: wr_req=0. If pend_cnt>0, go to REQ_T1.
  - REQ_T1: wr_req=1, wr_sel=TIME1, wr_data={1'b0, shadow_t1[13:0]+1}, recomputed every cycle from the current shadow.
    - On grant with no conflicting snoop: shadow_t1<=wr_data, pend_cnt decrements. If that was an overflow, go to REQ_T2; else go to REQ_T1 if pend_cnt-1>0, otherwise IDLE.
  - REQ_T2: wr_req=1, wr_sel=TIME2, wr_data={1'b0, shadow_t2[13:0]+1}.
    - On grant with no conflicting snoop: shadow_t2<=wr_data, then go to REQ_T1 if pend_cnt>0, else IDLE.
- Latency: tick to wr_req high is 2 cycles (pend update, then state register) when IDLE.
- wr_req holds, and wr_sel is stable, until grant. wr_data may change only because of a snoop.
- Snoop:
  - Any snoopN_en with snoopN_sel==TIME1 (or TIME2) loads that shadow with snoopN_data.
  - If both snoop ports target the same register, port 2 wins.
- Conflict: grant in a cycle where a snoop targets the register currently being requested.
  - The pipeline value wins. The timer commit is void: no pend decrement, no state advance.
  - The request repeats next cycle with the new shadow+1.
  - A TIME2 conflict is handled the same way, and the TIME2 carry is still owed.
- Reset mid-request: wr_req drops immediately (async) and all pending ticks are discarded.

Decomposition:
- Shared package internal_defines: reg_t (including TIME1, TIME2) and TIMER_W=14.
- One sub-module, tick_prescaler (TICK_DIV parameter; ports clock, rst, tick).
- Everything else stays in agc_timer_writer.

Test Plan:
- TICK_DIV=4, grant tied 1, from reset → wr_req first high at cycle 6 with TIME1/0x0001. After 3 ticks, shadow_t1=3 and pend_cnt=0.
- Preload shadow_t1=0x3FFF, shadow_t2=0x0005 via snoop, one tick, grant=1 → writes TIME1=0x0000 then TIME2=0x0006 on consecutive grants, then IDLE.
- grant=0 for 40 cycles with TICK_DIV=4, MAX_PEND=7 → pend_cnt saturates at 7 and overrun=1. wr_req/wr_sel stay stable. Releasing grant produces 7 TIME1 commits: values 1..7.
- Requesting TIME1 with shadow=0x0010; in the grant cycle snoop2 writes TIME1=0x0100 → no decrement; next cycle wr_data=0x0101 commits and pend_cnt drops by 1.
- snoop1 and snoop2 both write TIME2 (0x0011 and 0x0022) in the same cycle → shadow_t2=0x0022, and the next TIME2 request carries 0x0023.
- Assert rst while wr_req=1 with pend_cnt=3 → wr_req=0 and pend_cnt=0 in the same cycle; after release, no write until the next tick.

Source files
------------

// File: rtl/internal_defines.sv
// Shared register addresses, timer widths and FSM encoding for the
// timer-register write port.
package internal_defines;

  localparam int TIMER_W = 14;
  localparam int DATA_W  = 15;

  typedef enum logic [4:0] {
    REG_A    = 5'o00,
    REG_L    = 5'o01,
    REG_Q    = 5'o02,
    REG_EB   = 5'o03,
    REG_FB   = 5'o04,
    REG_Z    = 5'o05,
    REG_BB   = 5'o06,
    REG_ZERO = 5'o07,
    TIME2    = 5'o24,
    TIME1    = 5'o25
  } reg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_T1 = 2'd1,
    REQ_T2 = 2'd2
  } state_t;

  // Timer registers count modulo 2^14; bit 14 of the written word is always 0.
  function automatic logic [DATA_W-1:0] timer_inc(input logic [TIMER_W-1:0] v);
    timer_inc = {1'b0, v + TIMER_W'(1)};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the core clock into single-cycle timer ticks; the tick is high
// on the cycle the counter has just wrapped to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clock,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CNT_W'(TICK_DIV - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/agc_timer_writer.sv
// Timer-register writer: turns prescaled ticks into TIME1/TIME2 increments on
// the register file's second write port, keeping shadows in step with the pipeline.
module agc_timer_writer
  import internal_defines::*;
#(
  parameter  int TICK_DIV = 100000,
  parameter  int MAX_PEND = 7,
  localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              grant,
  input  logic              snoop1_en,
  input  reg_t              snoop1_sel,
  input  logic [DATA_W-1:0] snoop1_data,
  input  logic              snoop2_en,
  input  reg_t              snoop2_sel,
  input  logic [DATA_W-1:0] snoop2_data,
  output logic              wr_req,
  output reg_t              wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overrun
);

  state_t             state;
  state_t             state_next;
  logic               tick;
  logic [TIMER_W-1:0] shadow_t1;
  logic [TIMER_W-1:0] shadow_t2;
  logic [PEND_W-1:0]  pend_next;
  logic               snoop_t1;
  logic               snoop_t2;
  logic [TIMER_W-1:0] snoop_t1_data;
  logic [TIMER_W-1:0] snoop_t2_data;
  logic               commit_t1;
  logic               commit_t2;
  logic               t1_overflow;
  logic               saturated;
  logic               unused_bits;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock(clock),
    .rst  (rst),
    .tick (tick)
  );

  // Only bits 13:0 of a pipeline write are architecturally meaningful.
  assign unused_bits = snoop1_data[DATA_W-1] ^ snoop2_data[DATA_W-1];

  // Port 2 is evaluated last so it wins when both ports hit the same register.
  always_comb begin
    snoop_t1      = 1'b0;
    snoop_t2      = 1'b0;
    snoop_t1_data = '0;
    snoop_t2_data = '0;
    if (snoop1_en && snoop1_sel == TIME1) begin
      snoop_t1      = 1'b1;
      snoop_t1_data = snoop1_data[TIMER_W-1:0];
    end
    if (snoop1_en && snoop1_sel == TIME2) begin
      snoop_t2      = 1'b1;
      snoop_t2_data = snoop1_data[TIMER_W-1:0];
    end
    if (snoop2_en && snoop2_sel == TIME1) begin
      snoop_t1      = 1'b1;
      snoop_t1_data = snoop2_data[TIMER_W-1:0];
    end
    if (snoop2_en && snoop2_sel == TIME2) begin
      snoop_t2      = 1'b1;
      snoop_t2_data = snoop2_data[TIMER_W-1:0];
    end
  end

  // A grant that coincides with a pipeline write to the same register is void.
  assign commit_t1   = (state == REQ_T1) && grant && !snoop_t1;
  assign commit_t2   = (state == REQ_T2) && grant && !snoop_t2;
  assign t1_overflow = &shadow_t1;
  assign saturated   = (pend_cnt == PEND_W'(MAX_PEND));

  always_comb begin
    pend_next = pend_cnt;
    if (tick && !commit_t1) begin
      if (!saturated) pend_next = pend_cnt + PEND_W'(1);
    end else if (commit_t1 && !tick) begin
      pend_next = pend_cnt - PEND_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pend_cnt  <= '0;
      overrun   <= 1'b0;
      shadow_t1 <= '0;
      shadow_t2 <= '0;
    end else begin
      pend_cnt <= pend_next;
      if (tick && !commit_t1 && saturated) overrun <= 1'b1;
      if (snoop_t1)       shadow_t1 <= snoop_t1_data;
      else if (commit_t1) shadow_t1 <= wr_data[TIMER_W-1:0];
      if (snoop_t2)       shadow_t2 <= snoop_t2_data;
      else if (commit_t2) shadow_t2 <= wr_data[TIMER_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (pend_cnt != '0) state_next = REQ_T1;
      end
      REQ_T1: begin
        if (commit_t1) begin
          if (t1_overflow)                 state_next = REQ_T2;
          else if (pend_cnt > PEND_W'(1))  state_next = REQ_T1;
          else                             state_next = IDLE;
        end
      end
      REQ_T2: begin
        if (commit_t2) state_next = (pend_cnt != '0) ? REQ_T1 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state and shadows.
  always_comb begin
    wr_req  = 1'b0;
    wr_sel  = TIME1;
    wr_data = '0;
    unique case (state)
      REQ_T1: begin
        wr_req  = 1'b1;
        wr_sel  = TIME1;
        wr_data = timer_inc(shadow_t1);
      end
      REQ_T2: begin
        wr_req  = 1'b1;
        wr_sel  = TIME2;
        wr_data = timer_inc(shadow_t2);
      end
      default: begin
        wr_req  = 1'b0;
        wr_sel  = TIME1;
        wr_data = '0;
      end
    endcase
  end

endmodule
